// File: rtl/hazard_pkg.sv
// Shared types and width helpers for the scoreboard hazard unit.
package hazard_pkg;

  // Operand source encoding; values above FWD_RF name the stage after issue.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_X  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  // Width of a forward-select field able to encode 0..fwd_stg.
  function automatic int unsigned sel_w(input int unsigned fwd_stg);
    return $clog2(fwd_stg + 1);
  endfunction

  // Width of the producer-latency field able to encode 0..max_lat.
  function automatic int unsigned lat_w(input int unsigned max_lat);
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/hs_entry.sv
// One scoreboard entry: valid/age/remaining-latency for a single register.
module hs_entry
  import hazard_pkg::*;
#(
  parameter int unsigned LAT_W   = 3,
  parameter int unsigned AGE_W   = 2,
  parameter int unsigned FWD_STG = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_hit,
  input  logic [LAT_W-1:0] issue_cnt,
  input  logic             advance,
  input  logic             flush,
  output logic             valid,
  output logic [AGE_W-1:0] age,
  output logic [LAT_W-1:0] cnt,
  output logic             valid_nxt_c
);

  logic [AGE_W-1:0] age_nxt;
  logic [LAT_W-1:0] cnt_nxt;

  // Entry state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      age   <= '0;
      cnt   <= '0;
    end else begin
      valid <= valid_nxt_c;
      age   <= age_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // New issue overwrites; else flush kills age-1, advance ages/retires, freeze holds.
  always_comb begin
    valid_nxt_c = valid;
    age_nxt     = age;
    cnt_nxt     = cnt;
    if (issue_hit) begin
      valid_nxt_c = 1'b1;
      age_nxt     = AGE_W'(1);
      cnt_nxt     = issue_cnt;
    end else if (valid) begin
      if (flush && (age == AGE_W'(1))) begin
        valid_nxt_c = 1'b0;
      end else if (advance) begin
        if (age == AGE_W'(FWD_STG)) begin
          valid_nxt_c = 1'b0;
        end else begin
          age_nxt = age + AGE_W'(1);
          if (cnt != '0) cnt_nxt = cnt - LAT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: tracks in-flight writes, resolves D-stage operand sources.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned MAX_LAT   = 4,
  parameter int unsigned FWD_STG   = 3,
  parameter int unsigned REG0_ZERO = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  issue_valid,
  input  logic                                  issue_wen,
  input  logic [REG_W-1:0]                      issue_rd,
  input  logic [lat_w(MAX_LAT)-1:0]             issue_lat,
  input  logic [NUM_RD*REG_W-1:0]               d_rs,
  input  logic [NUM_RD-1:0]                     d_rs_used,
  input  logic                                  mem_ready,
  input  logic                                  flush,
  output logic                                  stall_o,
  output logic [NUM_RD*sel_w(FWD_STG)-1:0]      fwd_sel,
  output logic [REG_W:0]                        pending_cnt
);

  localparam int unsigned LAT_W   = lat_w(MAX_LAT);
  localparam int unsigned SEL_W   = sel_w(FWD_STG);
  localparam int unsigned NUM_ENT = 2 ** REG_W;
  localparam int unsigned CNT_W   = REG_W + 1;

  logic               issue_fire_c;
  logic [LAT_W-1:0]   issue_cnt_c;
  logic [NUM_ENT-1:0] ent_valid;
  logic [NUM_ENT-1:0] ent_valid_nxt_c;
  logic [SEL_W-1:0]   ent_age [NUM_ENT];
  logic [LAT_W-1:0]   ent_cnt [NUM_ENT];
  logic [NUM_RD-1:0]  hazard_c;
  logic [CNT_W-1:0]   pending_nxt_c;

  // Issue qualification; register 0 is never tracked when hardwired zero.
  always_comb begin
    issue_fire_c = issue_valid & issue_wen & ~stall_o & mem_ready & ~flush;
    if ((REG0_ZERO != 0) && (issue_rd == '0)) issue_fire_c = 1'b0;
    issue_cnt_c = (issue_lat == '0) ? '0 : issue_lat - LAT_W'(1);
  end

  for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
    hs_entry #(
      .LAT_W   (LAT_W),
      .AGE_W   (SEL_W),
      .FWD_STG (FWD_STG)
    ) u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_hit   (issue_fire_c && (issue_rd == REG_W'(g))),
      .issue_cnt   (issue_cnt_c),
      .advance     (mem_ready),
      .flush       (flush),
      .valid       (ent_valid[g]),
      .age         (ent_age[g]),
      .cnt         (ent_cnt[g]),
      .valid_nxt_c (ent_valid_nxt_c[g])
    );
  end

  // Per-port lookup against current entry state: RF, forward stage, or hazard.
  always_comb begin
    logic [REG_W-1:0] rs;
    fwd_sel  = '0;
    hazard_c = '0;
    rs       = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rs = d_rs[i*REG_W +: REG_W];
      fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
      if (d_rs_used[i] && ent_valid[rs] && !((REG0_ZERO != 0) && (rs == '0))) begin
        if (ent_cnt[rs] == '0) fwd_sel[i*SEL_W +: SEL_W] = ent_age[rs];
        else                   hazard_c[i] = 1'b1;
      end
    end
  end

  assign stall_o = issue_valid & (|hazard_c);

  // Population count of entries valid after the coming edge.
  always_comb begin
    pending_nxt_c = '0;
    for (int e = 0; e < NUM_ENT; e++) begin
      pending_nxt_c = pending_nxt_c + CNT_W'(ent_valid_nxt_c[e]);
    end
  end

  // Registered pending count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_cnt <= '0;
    else        pending_cnt <= pending_nxt_c;
  end

endmodule
